riscv_retire_checker: RTL and testbench

Synthesizable self-check block for the pipelined RISC-V core's test environment. It watches the core's retired-instruction count `NUM_INST`, its `OUTPUT_PORT` and its `HALT` output. At each programmed checkpoint it compares the output against a loaded answer table and produces a latched pass/fail verdict with diagnostics. It sits beside `RISCV_TOP` in the bench or on an FPGA wrapper. It is the parametrised successor of the fixed 26-entry bench check: table depth and data width are configurable, and it adds skip detection, premature-halt detection, timeout and a cycle counter.

---
 rtl/riscv_retire_checker.sv | 176 +++++++++++++++++
 tb/tb_riscv_retire_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_retire_checker.sv
// riscv_retire_checker: checks core output at programmed retire counts.
// Optional STALL_CNT counter built with RETIRE_CHECKER_STALL_CNT_EN.
module riscv_retire_checker #(
  parameter int NUM_TEST = 32,
  parameter int DWIDTH = 32,
  parameter int TIMEOUT = 1000000,
  parameter int AW = $clog2(NUM_TEST)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TAB_WE,
  input  logic [AW-1:0]     TAB_ADDR,
  input  logic [31:0]       TAB_NUM_INST,
  input  logic [DWIDTH-1:0] TAB_ANS,
  input  logic [AW:0]       TAB_LEN,
  input  logic              START,
  input  logic [31:0]       NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [2:0]        FAIL_CODE,
  output logic [AW-1:0]     FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VAL,
  output logic [AW:0]       PASS_CNT,
  output logic [31:0]       CYCLE,
  output logic [31:0]       STALL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_t;

  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t state, state_n;

  logic [31:0]       tab_ni  [DEPTH];
  logic [DWIDTH-1:0] tab_ans [DEPTH];

  logic [AW:0]       len;
  logic [AW:0]       ptr;
  logic [AW:0]       ptr_nx;
  logic [31:0]       cycle;
  logic [2:0]        fail_code;
  logic [2:0]        code_n;
  logic [AW-1:0]     fail_idx;
  logic [DWIDTH-1:0] fail_val;
  logic [31:0]       cur_ni;
  logic [DWIDTH-1:0] cur_ans;
  logic              pend;
  logic              hit;
  logic              match;
  logic              skip;
  logic              adv;

  // Table load; only accepted while idle
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && TAB_WE) begin
      tab_ni[TAB_ADDR]  <= TAB_NUM_INST;
      tab_ans[TAB_ADDR] <= TAB_ANS;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and checkpoint evaluation in priority order
  always_comb begin
    state_n = state;
    code_n  = 3'd0;
    adv     = 1'b0;
    cur_ni  = tab_ni[ptr[AW-1:0]];
    cur_ans = tab_ans[ptr[AW-1:0]];
    pend    = ptr < len;
    hit     = pend && (NUM_INST == cur_ni);
    skip    = pend && (NUM_INST > cur_ni);
    match   = OUTPUT_PORT == cur_ans;
    ptr_nx  = ptr + {{AW{1'b0}}, hit && match};
    unique case (state)
      S_IDLE: begin
        if (START) state_n = S_RUN;
      end
      S_RUN: begin
        if (TIMEOUT != 0 && cycle == TO_LAST) begin
          state_n = S_FAIL;
          code_n  = 3'd4;
        end else if (hit && !match) begin
          state_n = S_FAIL;
          code_n  = 3'd1;
        end else if (skip) begin
          state_n = S_FAIL;
          code_n  = 3'd2;
        end else begin
          adv = hit;
          if (HALT) begin
            if (ptr_nx == len) begin
              state_n = S_PASS;
            end else begin
              state_n = S_FAIL;
              code_n  = 3'd3;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Run counters and failure diagnostics
  always_ff @(posedge CLK) begin
    if (RST) begin
      len       <= '0;
      ptr       <= '0;
      cycle     <= '0;
      fail_code <= '0;
      fail_idx  <= '0;
      fail_val  <= '0;
    end else if (state == S_IDLE && START) begin
      len       <= TAB_LEN;
      ptr       <= '0;
      cycle     <= '0;
      fail_code <= '0;
      fail_idx  <= '0;
      fail_val  <= '0;
    end else if (state == S_RUN) begin
      if (adv) ptr <= ptr_nx;
      if (state_n == S_RUN && cycle != '1)
        cycle <= cycle + 32'd1;
      if (state_n == S_FAIL) begin
        fail_code <= code_n;
        fail_idx  <= ptr[AW-1:0];
        fail_val  <= OUTPUT_PORT;
      end
    end
  end

`ifdef RETIRE_CHECKER_STALL_CNT_EN
  logic [31:0] prev_ni;
  logic [31:0] stall;

  // Count RUN cycles where the retire count did not move
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_ni <= '0;
      stall   <= '0;
    end else begin
      prev_ni <= NUM_INST;
      if (state == S_IDLE && START)
        stall <= '0;
      else if (state == S_RUN && state_n == S_RUN
               && NUM_INST == prev_ni && stall != '1)
        stall <= stall + 32'd1;
    end
  end

  assign STALL_CNT = stall;
`else
  assign STALL_CNT = '0;
`endif

  assign BUSY      = state == S_RUN;
  assign DONE      = state == S_PASS || state == S_FAIL;
  assign PASS      = state == S_PASS;
  assign FAIL_CODE = fail_code;
  assign FAIL_IDX  = fail_idx;
  assign FAIL_VAL  = fail_val;
  assign PASS_CNT  = ptr;
  assign CYCLE     = cycle;

endmodule

// File: tb/tb_riscv_retire_checker.sv
// tb_riscv_retire_checker: directed scenarios for the retire checker.
// Expected values are hand-computed per scenario.
module tb_riscv_retire_checker;

  localparam int NT = 32;
  localparam int DW = 32;
  localparam int TO = 100;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          TAB_WE = 1'b0;
  logic [AW-1:0] TAB_ADDR = '0;
  logic [31:0]   TAB_NUM_INST = '0;
  logic [DW-1:0] TAB_ANS = '0;
  logic [AW:0]   TAB_LEN = '0;
  logic          START = 1'b0;
  logic [31:0]   NUM_INST = '0;
  logic [DW-1:0] OUTPUT_PORT = '0;
  logic          HALT = 1'b0;
  logic          BUSY;
  logic          DONE;
  logic          PASS;
  logic [2:0]    FAIL_CODE;
  logic [AW-1:0] FAIL_IDX;
  logic [DW-1:0] FAIL_VAL;
  logic [AW:0]   PASS_CNT;
  logic [31:0]   CYCLE;
  logic [31:0]   STALL_CNT;

  int total = 0;
  int bad = 0;

  riscv_retire_checker #(
    .NUM_TEST(NT), .DWIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .TAB_WE(TAB_WE), .TAB_ADDR(TAB_ADDR),
    .TAB_NUM_INST(TAB_NUM_INST), .TAB_ANS(TAB_ANS),
    .TAB_LEN(TAB_LEN), .START(START),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
    .HALT(HALT), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .FAIL_CODE(FAIL_CODE), .FAIL_IDX(FAIL_IDX),
    .FAIL_VAL(FAIL_VAL), .PASS_CNT(PASS_CNT),
    .CYCLE(CYCLE), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    TAB_WE = 1'b0;
    HALT = 1'b0;
    NUM_INST = '0;
    OUTPUT_PORT = '0;
    step();
    RST = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] ni,
                      input logic [31:0] ans);
    TAB_WE = 1'b1;
    TAB_ADDR = AW'(a);
    TAB_NUM_INST = ni;
    TAB_ANS = ans;
    step();
    TAB_WE = 1'b0;
  endtask

  task automatic start(input int n);
    TAB_LEN = (AW+1)'(n);
    NUM_INST = '0;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic cyc(input logic [31:0] ni, input logic [31:0] o,
                     input logic h);
    NUM_INST = ni;
    OUTPUT_PORT = o;
    HALT = h;
    step();
    HALT = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({BUSY, DONE, PASS} !== 3'b000) begin
      bad++;
      $display("FAIL reset.flags got=%b want=000", {BUSY, DONE, PASS});
    end
    total++;
    if (FAIL_CODE !== 3'd0 || FAIL_IDX !== '0 || FAIL_VAL !== '0) begin
      bad++;
      $display("FAIL reset.diag got=%0h/%0h/%0h want=0/0/0",
               FAIL_CODE, FAIL_IDX, FAIL_VAL);
    end
    total++;
    if (PASS_CNT !== '0 || CYCLE !== '0 || STALL_CNT !== '0) begin
      bad++;
      $display("FAIL reset.cnt got=%0d/%0d/%0d want=0/0/0",
               PASS_CNT, CYCLE, STALL_CNT);
    end
  endtask

  task automatic test_pass();
    do_reset();
    load(0, 32'd1, 32'h0);
    load(1, 32'd2, 32'h0);
    load(2, 32'd3, 32'h5);
    start(3);
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL pass.busy got=%b want=1", BUSY);
    end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(2, 0, 0);
    cyc(3, 5, 0);
    cyc(3, 5, 1);
    total++;
    if ({BUSY, DONE, PASS} !== 3'b011) begin
      bad++;
      $display("FAIL pass.flags got=%b want=011", {BUSY, DONE, PASS});
    end
    total++;
    if (PASS_CNT !== 6'd3) begin
      bad++;
      $display("FAIL pass.cnt got=%0d want=3", PASS_CNT);
    end
    total++;
    if (FAIL_CODE !== 3'd0) begin
      bad++;
      $display("FAIL pass.code got=%0d want=0", FAIL_CODE);
    end
    total++;
    if (CYCLE !== 32'd4) begin
      bad++;
      $display("FAIL pass.cycle got=%0d want=4", CYCLE);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    start(3);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(2, 0, 0);
    cyc(3, 4, 0);
    total++;
    if ({DONE, PASS} !== 2'b10) begin
      bad++;
      $display("FAIL mism.flags got=%b want=10", {DONE, PASS});
    end
    total++;
    if (FAIL_CODE !== 3'd1 || FAIL_IDX !== 5'd2) begin
      bad++;
      $display("FAIL mism.code got=%0d/%0d want=1/2", FAIL_CODE, FAIL_IDX);
    end
    total++;
    if (FAIL_VAL !== 32'h4 || PASS_CNT !== 6'd2) begin
      bad++;
      $display("FAIL mism.val got=%0h/%0d want=4/2", FAIL_VAL, PASS_CNT);
    end
  endtask

  task automatic test_skip();
    do_reset();
    load(0, 32'd5, 32'hA);
    load(1, 32'd6, 32'hB);
    start(2);
    cyc(4, 0, 0);
    cyc(4, 0, 0);
    total++;
    if (BUSY !== 1'b1 || FAIL_CODE !== 3'd0) begin
      bad++;
      $display("FAIL skip.hold got=%b/%0d want=1/0", BUSY, FAIL_CODE);
    end
    cyc(6, 32'h77, 0);
    total++;
    if (FAIL_CODE !== 3'd2 || FAIL_IDX !== 5'd0) begin
      bad++;
      $display("FAIL skip.code got=%0d/%0d want=2/0", FAIL_CODE, FAIL_IDX);
    end
    total++;
    if (FAIL_VAL !== 32'h77 || DONE !== 1'b1) begin
      bad++;
      $display("FAIL skip.val got=%0h/%b want=77/1", FAIL_VAL, DONE);
    end
  endtask

  task automatic test_empty();
    do_reset();
    start(0);
    cyc(0, 0, 0);
    total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL empty.run got=%b/%b want=1/0", BUSY, DONE);
    end
    cyc(0, 0, 1);
    total++;
    if (PASS !== 1'b1 || PASS_CNT !== 6'd0) begin
      bad++;
      $display("FAIL empty.pass got=%b/%0d want=1/0", PASS, PASS_CNT);
    end
  endtask

  task automatic test_premature_halt();
    do_reset();
    for (int i = 0; i < 26; i++)
      load(i, 32'(i + 1), 32'h100 + 32'(i));
    start(26);
    for (int i = 0; i < 24; i++)
      cyc(32'(i + 1), 32'h100 + 32'(i), 0);
    cyc(24, 32'h55, 1);
    total++;
    if (FAIL_CODE !== 3'd3 || PASS_CNT !== 6'd24) begin
      bad++;
      $display("FAIL early.code got=%0d/%0d want=3/24", FAIL_CODE, PASS_CNT);
    end
    total++;
    if (FAIL_IDX !== 5'd24 || FAIL_VAL !== 32'h55) begin
      bad++;
      $display("FAIL early.diag got=%0d/%0h want=24/55", FAIL_IDX, FAIL_VAL);
    end
  endtask

  task automatic test_same_cycle_halt();
    do_reset();
    start(26);
    TAB_WE = 1'b1;
    TAB_ADDR = 5'd25;
    TAB_NUM_INST = 32'd26;
    TAB_ANS = 32'hDEAD;
    for (int i = 0; i < 25; i++) begin
      cyc(32'(i + 1), 32'h100 + 32'(i), 0);
      TAB_WE = 1'b0;
    end
    cyc(26, 32'h119, 1);
    total++;
    if (PASS !== 1'b1 || PASS_CNT !== 6'd26) begin
      bad++;
      $display("FAIL same.pass got=%b/%0d want=1/26", PASS, PASS_CNT);
    end
    total++;
    if (FAIL_CODE !== 3'd0) begin
      bad++;
      $display("FAIL same.code got=%0d want=0", FAIL_CODE);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp_stall;
`ifdef RETIRE_CHECKER_STALL_CNT_EN
    exp_stall = 32'd99;
`else
    exp_stall = 32'd0;
`endif
    do_reset();
    start(26);
    for (int i = 0; i < 99; i++)
      cyc(0, 0, 0);
    total++;
    if (BUSY !== 1'b1 || FAIL_CODE !== 3'd0) begin
      bad++;
      $display("FAIL tmo.early got=%b/%0d want=1/0", BUSY, FAIL_CODE);
    end
    cyc(0, 0, 0);
    total++;
    if (FAIL_CODE !== 3'd4 || DONE !== 1'b1) begin
      bad++;
      $display("FAIL tmo.code got=%0d/%b want=4/1", FAIL_CODE, DONE);
    end
    total++;
    if (CYCLE !== 32'd99) begin
      bad++;
      $display("FAIL tmo.cycle got=%0d want=99", CYCLE);
    end
    total++;
    if (STALL_CNT !== exp_stall) begin
      bad++;
      $display("FAIL tmo.stall got=%0d want=%0d", STALL_CNT, exp_stall);
    end
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    load(0, 32'd1, 32'h0);
    load(1, 32'd2, 32'h0);
    load(2, 32'd3, 32'h5);
    start(3);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    total++;
    if (BUSY !== 1'b1 || PASS_CNT !== 6'd1) begin
      bad++;
      $display("FAIL rst.run got=%b/%0d want=1/1", BUSY, PASS_CNT);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if ({BUSY, DONE, PASS, FAIL_CODE} !== 6'd0) begin
      bad++;
      $display("FAIL rst.flags got=%b want=0", {BUSY, DONE, PASS, FAIL_CODE});
    end
    total++;
    if (PASS_CNT !== '0 || CYCLE !== '0 || STALL_CNT !== '0) begin
      bad++;
      $display("FAIL rst.cnt got=%0d/%0d/%0d want=0/0/0",
               PASS_CNT, CYCLE, STALL_CNT);
    end
    start(3);
    cyc(1, 0, 0);
    cyc(2, 0, 0);
    cyc(3, 5, 1);
    total++;
    if (PASS !== 1'b1 || PASS_CNT !== 6'd3) begin
      bad++;
      $display("FAIL rst.rerun got=%b/%0d want=1/3", PASS, PASS_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_skip();
    test_empty();
    test_premature_halt();
    test_same_cycle_halt();
    test_timeout();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
